chan_err_inj: RTL and testbench
===============================

Name: chan_err_inj

Overview:
Channel-impairment stage between the convolutional encoder output and the Viterbi decoder input. It takes encoder 2-bit symbols with a valid strobe and re-times them by one register. Within a finite test window it corrupts selected bits using a periodic, burst, or LFSR-random pattern. It also keeps symbol and injected-bit-error counts so the bench can correlate decoder output against channel BER.

Parameters:
PERIOD_LOG2, 4, error trigger period is 2**PERIOD_LOG2 valid symbols (periodic and burst modes)
MAX_SYMS, 256, injection window length in valid symbols; no corruption at or beyond it
LFSR_SEED, 16'hABCD, reset value of the random-mode LFSR (must be nonzero)
CNT_W, 16, width of the statistics counters

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous active-low reset
valid_i  input  1  symbol strobe from the encoder (its valid output)
sym_i  input  2  encoder symbol {g1,g0}
mode_i  input  2  00 pass, 01 periodic, 10 burst, 11 random
mask_i  input  2  bits to invert in periodic and burst modes
burst_len_i  input  4  burst length in symbols; 0 is treated as 1
thresh_i  input  8  random-mode per-bit inject threshold
valid_o  output  1  registered valid_i; drives the decoder enable
sym_o  output  2  sym_i XOR err_o, registered
err_o  output  2  error mask applied to the current sym_o
sym_ct_o  output  CNT_W  valid symbols seen, saturates at MAX_SYMS
bit_err_ct_o  output  CNT_W  total bits inverted, saturating at all-ones
done_o  output  1  high once sym_ct_o == MAX_SYMS

Behaviour:
- Reset (rst==0 at a clk edge):
  - valid_o, sym_o, err_o, sym_ct_o, bit_err_ct_o and done_o all go to 0.
  - LFSR loads LFSR_SEED; burst FSM goes to IDLE with remaining=0.
  - Reset mid-burst or mid-window abandons all state.
- Latency: exactly 1 cycle. valid_o(t+1)=valid_i(t); sym_o(t+1)=sym_i(t)^e(t); err_o(t+1)=e(t).
- When valid_i=0: valid_o=0, err_o=0, sym_o holds its last value, no counter/LFSR/FSM advance.
- Window: inj_en = valid_i && (sym_ct < MAX_SYMS). When inj_en=0, e=00. sym_ct increments on valid_i until it reaches MAX_SYMS, then holds; done_o is registered from sym_ct==MAX_SYMS.
- trig = inj_en && (sym_ct[PERIOD_LOG2-1:0] == all-ones).
- Pass mode: e=00.
- Periodic mode: e = trig ? mask_i : 00.
- Burst mode, FSM IDLE/BURST:
  - IDLE: on trig, e=mask_i. If max(burst_len_i,1) > 1, go to BURST with remaining = max(burst_len_i,1)-1.
  - BURST: each inj_en symbol gives e=mask_i and decrements remaining; leave for IDLE when remaining reaches 0 after the decrement.
  - A trig while in BURST does not restart the count.
  - mode_i != 10 while in BURST forces IDLE on the next edge.
  - Window end while in BURST gives e=00 and forces IDLE.
- Random mode:
  - 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1, steps once per inj_en symbol.
  - e[0] = (lfsr[7:0] < thresh_i); e[1] = (lfsr[15:8] < thresh_i), using the pre-step LFSR value.
  - thresh_i=0 means no errors. The LFSR does not step in other modes.
- bit_err_ct += popcount(e) on each valid symbol, saturating.
- Mode and config inputs are sampled every cycle; changing them takes effect on the next symbol, apart from the forced BURST exit above.

Decomposition:
- Package chan_pkg holds:
  - typedef enum for mode (MODE_PASS, MODE_PERIODIC, MODE_BURST, MODE_RANDOM);
  - typedef enum for the burst FSM (B_IDLE, B_BURST);
  - constant LFSR_TAPS = 16'hB400.
- Sub-module chan_lfsr16 (ports: clk, rst, step, seed parameter, q[15:0]) holds the random generator so it can be reused for data sources.
- Everything else stays in chan_err_inj.

Test Plan:
- Pass mode, 300 consecutive valid symbols sym_i=01 -> sym_o=01 one cycle later, err_o=00 throughout, bit_err_ct_o=0; sym_ct_o stops at 256 and done_o rises on the cycle after the 256th symbol.
- Periodic mode, mask_i=11, 32 valid symbols sym_i=01 -> sym_o=10 only for symbol indices 15 and 31; bit_err_ct_o=4.
- Burst mode, mask_i=01, burst_len_i=3, 40 valid symbols sym_i=00 -> sym_o=01 at indices 15,16,17,31,32,33; bit_err_ct_o=6. With burst_len_i=0 -> only indices 15 and 31.
- Burst mode with valid_i gaps inside the burst (valid_i low 2 cycles after index 15) -> burst still covers 3 valid symbols; no errors reported while valid_i is low.
- Random mode, thresh_i=0, 100 symbols -> no errors. Random mode, thresh_i=8'hFF -> matches a reference-model LFSR from seed ABCD, with every bit flipped unless its LFSR byte is FF.
- rst driven low for 1 cycle at index 16 in burst mode -> next cycle all outputs 0; the following trig is at the new index 15, and no residual burst symbols appear.

Source files
------------

// File: rtl/chan_pkg.sv
// Shared types and constants for the channel error-injection stage.
package chan_pkg;

  typedef enum logic [1:0] {
    MODE_PASS     = 2'b00,
    MODE_PERIODIC = 2'b01,
    MODE_BURST    = 2'b10,
    MODE_RANDOM   = 2'b11
  } mode_e;

  typedef enum logic {
    B_IDLE  = 1'b0,
    B_BURST = 1'b1
  } burst_st_e;

  // Galois feedback mask for x^16+x^14+x^13+x^11+1 (right-shifting form)
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Number of set bits in a 2-bit error mask
  function automatic logic [1:0] popcnt2(input logic [1:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]};
  endfunction

endpackage

// File: rtl/chan_lfsr16.sv
// 16-bit Galois LFSR; advances one step per cycle with step asserted.
module chan_lfsr16
  import chan_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hABCD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        step,
  output logic [15:0] q
);

  logic [15:0] lfsr_q, lfsr_d;

  // Next state: shift right, fold feedback in when the bit shifted out is set
  always_comb begin
    lfsr_d = lfsr_q;
    if (step) begin
      lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
    end
  end

  // State register with synchronous active-low reset to the seed
  always_ff @(posedge clk) begin
    if (!rst) lfsr_q <= SEED;
    else      lfsr_q <= lfsr_d;
  end

  assign q = lfsr_q;

endmodule

// File: rtl/chan_err_inj.sv
// Channel impairment stage: re-times encoder symbols by one register and, inside a
// finite window, flips bits in periodic, burst or LFSR-random patterns while counting
// symbols and injected bit errors.
module chan_err_inj
  import chan_pkg::*;
#(
  parameter int unsigned PERIOD_LOG2 = 4,
  parameter int unsigned MAX_SYMS    = 256,
  parameter logic [15:0] LFSR_SEED   = 16'hABCD,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  input  logic [1:0]       sym_i,
  input  logic [1:0]       mode_i,
  input  logic [1:0]       mask_i,
  input  logic [3:0]       burst_len_i,
  input  logic [7:0]       thresh_i,
  output logic             valid_o,
  output logic [1:0]       sym_o,
  output logic [1:0]       err_o,
  output logic [CNT_W-1:0] sym_ct_o,
  output logic [CNT_W-1:0] bit_err_ct_o,
  output logic             done_o
);

  localparam logic [CNT_W-1:0] MaxCt = CNT_W'(MAX_SYMS);

  logic             valid_q, valid_d;
  logic [1:0]       sym_q, sym_d;
  logic [1:0]       err_q, err_d;
  logic [CNT_W-1:0] sym_ct_q, sym_ct_d;
  logic [CNT_W-1:0] bec_q, bec_d;
  logic             done_q, done_d;
  burst_st_e        state_q, state_d;
  logic [3:0]       rem_q, rem_d;

  mode_e       mode;
  logic        in_window;
  logic        inj_en;
  logic        trig;
  logic [3:0]  blen_eff;
  logic [1:0]  e;
  logic        lfsr_step;
  logic [15:0] lfsr;
  logic [CNT_W:0] bec_sum;

  assign mode      = mode_e'(mode_i);
  assign in_window = (sym_ct_q < MaxCt);
  assign inj_en    = valid_i && in_window;
  assign trig      = inj_en && (&sym_ct_q[PERIOD_LOG2-1:0]);
  assign blen_eff  = (burst_len_i == 4'd0) ? 4'd1 : burst_len_i;

  chan_lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .step (lfsr_step),
    .q    (lfsr)
  );

  // Error-pattern selection and burst FSM next state
  always_comb begin
    e         = 2'b00;
    lfsr_step = 1'b0;
    state_d   = state_q;
    rem_d     = rem_q;
    unique case (mode)
      MODE_PASS: ;
      MODE_PERIODIC: begin
        if (trig) e = mask_i;
      end
      MODE_BURST: begin
        unique case (state_q)
          B_IDLE: begin
            if (trig) begin
              e = mask_i;
              if (blen_eff > 4'd1) begin
                state_d = B_BURST;
                rem_d   = blen_eff - 4'd1;
              end
            end
          end
          B_BURST: begin
            if (!in_window) begin
              state_d = B_IDLE;
              rem_d   = 4'd0;
            end else if (inj_en) begin
              // A trig here is deliberately ignored: the burst runs to its length
              e     = mask_i;
              rem_d = rem_q - 4'd1;
              if (rem_q == 4'd1) state_d = B_IDLE;
            end
          end
        endcase
      end
      MODE_RANDOM: begin
        if (inj_en) begin
          lfsr_step = 1'b1;
          e[0]      = (lfsr[7:0] < thresh_i);
          e[1]      = (lfsr[15:8] < thresh_i);
        end
      end
    endcase
    // Leaving burst mode abandons any burst in progress
    if (mode != MODE_BURST) begin
      state_d = B_IDLE;
      rem_d   = 4'd0;
    end
  end

  // Output pipeline and statistics next state
  always_comb begin
    valid_d  = valid_i;
    err_d    = e;
    sym_d    = valid_i ? (sym_i ^ e) : sym_q;
    sym_ct_d = sym_ct_q;
    if (valid_i && in_window) sym_ct_d = sym_ct_q + 1'b1;
    bec_sum = {1'b0, bec_q} + (CNT_W + 1)'(popcnt2(e));
    bec_d   = bec_q;
    if (valid_i) bec_d = bec_sum[CNT_W] ? '1 : bec_sum[CNT_W-1:0];
    // Registered alongside sym_ct so done_o tracks sym_ct_o exactly
    done_d = (sym_ct_d == MaxCt);
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q  <= 1'b0;
      sym_q    <= 2'b00;
      err_q    <= 2'b00;
      sym_ct_q <= '0;
      bec_q    <= '0;
      done_q   <= 1'b0;
      state_q  <= B_IDLE;
      rem_q    <= 4'd0;
    end else begin
      valid_q  <= valid_d;
      sym_q    <= sym_d;
      err_q    <= err_d;
      sym_ct_q <= sym_ct_d;
      bec_q    <= bec_d;
      done_q   <= done_d;
      state_q  <= state_d;
      rem_q    <= rem_d;
    end
  end

  assign valid_o      = valid_q;
  assign sym_o        = sym_q;
  assign err_o        = err_q;
  assign sym_ct_o     = sym_ct_q;
  assign bit_err_ct_o = bec_q;
  assign done_o       = done_q;

endmodule

// File: tb/tb_chan_err_inj.sv
// Self-checking bench for chan_err_inj: table-driven scenarios plus hand-written
// sequences for pass-mode saturation, random mode, valid gaps and mid-burst reset.
module tb_chan_err_inj;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic [1:0]  sym_i, mode_i, mask_i;
  logic [3:0]  burst_len_i;
  logic [7:0]  thresh_i;
  logic        valid_o;
  logic [1:0]  sym_o, err_o;
  logic [15:0] sym_ct_o, bit_err_ct_o;
  logic        done_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  chan_err_inj dut (
    .clk          (clk),
    .rst          (rst),
    .valid_i      (valid_i),
    .sym_i        (sym_i),
    .mode_i       (mode_i),
    .mask_i       (mask_i),
    .burst_len_i  (burst_len_i),
    .thresh_i     (thresh_i),
    .valid_o      (valid_o),
    .sym_o        (sym_o),
    .err_o        (err_o),
    .sym_ct_o     (sym_ct_o),
    .bit_err_ct_o (bit_err_ct_o),
    .done_o       (done_o)
  );

  typedef struct {
    logic [1:0]   mode;
    logic [1:0]   mask;
    logic [3:0]   blen;
    logic [7:0]   th;
    int           n;
    logic [1:0]   sym;
    logic [127:0] hit;   // symbol indices expected to be corrupted
    int           bec;
  } scen_t;

  scen_t scen [4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock with the given input; outputs are sampled 1 time unit after the edge
  task automatic send(input logic v, input logic [1:0] s);
    valid_i = v;
    sym_i   = s;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst     = 1'b0;
    valid_i = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic cfg(input logic [1:0] m, input logic [1:0] k, input logic [3:0] bl,
                     input logic [7:0] th);
    mode_i      = m;
    mask_i      = k;
    burst_len_i = bl;
    thresh_i    = th;
  endtask

  initial begin
    logic [1:0]  exp_e;
    logic [15:0] m;
    int          bec;

    rst = 1'b1; valid_i = 1'b0; sym_i = 2'b00;
    cfg(2'b00, 2'b00, 4'd0, 8'd0);

    scen[0] = '{mode: 2'b01, mask: 2'b11, blen: 4'd0, th: 8'd0, n: 32, sym: 2'b01,
                hit: (128'd1 << 15) | (128'd1 << 31), bec: 4};
    scen[1] = '{mode: 2'b10, mask: 2'b01, blen: 4'd3, th: 8'd0, n: 40, sym: 2'b00,
                hit: (128'd7 << 15) | (128'd7 << 31), bec: 6};
    scen[2] = '{mode: 2'b10, mask: 2'b01, blen: 4'd0, th: 8'd0, n: 40, sym: 2'b00,
                hit: (128'd1 << 15) | (128'd1 << 31), bec: 2};
    scen[3] = '{mode: 2'b11, mask: 2'b11, blen: 4'd0, th: 8'd0, n: 100, sym: 2'b10,
                hit: 128'd0, bec: 0};

    // Reset state
    do_reset();
    chk("rst_valid", 32'(valid_o), 0);
    chk("rst_sym", 32'(sym_o), 0);
    chk("rst_err", 32'(err_o), 0);
    chk("rst_symct", 32'(sym_ct_o), 0);
    chk("rst_bec", 32'(bit_err_ct_o), 0);
    chk("rst_done", 32'(done_o), 0);

    // Table-driven scenarios
    for (int s = 0; s < 4; s++) begin
      do_reset();
      cfg(scen[s].mode, scen[s].mask, scen[s].blen, scen[s].th);
      for (int k = 0; k < scen[s].n; k++) begin
        send(1'b1, scen[s].sym);
        exp_e = scen[s].hit[k] ? scen[s].mask : 2'b00;
        chk($sformatf("scen%0d_valid[%0d]", s, k), 32'(valid_o), 1);
        chk($sformatf("scen%0d_err[%0d]", s, k), 32'(err_o), 32'(exp_e));
        chk($sformatf("scen%0d_sym[%0d]", s, k), 32'(sym_o), 32'(scen[s].sym ^ exp_e));
      end
      chk($sformatf("scen%0d_bec", s), 32'(bit_err_ct_o), 32'(scen[s].bec));
      chk($sformatf("scen%0d_symct", s), 32'(sym_ct_o), 32'(scen[s].n));
    end

    // Pass mode across the window end: counter saturation and done
    do_reset();
    cfg(2'b00, 2'b11, 4'd0, 8'd0);
    for (int i = 0; i < 300; i++) begin
      send(1'b1, 2'b01);
      chk($sformatf("pass_sym[%0d]", i), 32'(sym_o), 1);
      chk($sformatf("pass_err[%0d]", i), 32'(err_o), 0);
      chk($sformatf("pass_symct[%0d]", i), 32'(sym_ct_o), (i + 1 < 256) ? i + 1 : 256);
      chk($sformatf("pass_done[%0d]", i), 32'(done_o), (i + 1 >= 256) ? 1 : 0);
    end
    chk("pass_bec", 32'(bit_err_ct_o), 0);

    // Random mode, threshold FF, against a reference LFSR from seed ABCD
    do_reset();
    cfg(2'b11, 2'b00, 4'd0, 8'hFF);
    m   = 16'hABCD;
    bec = 0;
    for (int i = 0; i < 100; i++) begin
      sym_i = 2'(i);
      exp_e = {m[15:8] != 8'hFF, m[7:0] != 8'hFF};
      bec  += int'(exp_e[0]) + int'(exp_e[1]);
      send(1'b1, 2'(i));
      chk($sformatf("rnd_err[%0d]", i), 32'(err_o), 32'(exp_e));
      chk($sformatf("rnd_sym[%0d]", i), 32'(sym_o), 32'(2'(i) ^ exp_e));
      m = m[0] ? ({1'b0, m[15:1]} ^ 16'hB400) : {1'b0, m[15:1]};
    end
    chk("rnd_bec", 32'(bit_err_ct_o), 32'(bec));

    // Burst with valid gaps inside the burst
    do_reset();
    cfg(2'b10, 2'b01, 4'd3, 8'd0);
    for (int i = 0; i < 16; i++) send(1'b1, 2'b00);
    chk("gap_err15", 32'(err_o), 1);
    for (int g = 0; g < 2; g++) begin
      send(1'b0, 2'b10);
      chk($sformatf("gap_valid[%0d]", g), 32'(valid_o), 0);
      chk($sformatf("gap_err[%0d]", g), 32'(err_o), 0);
      chk($sformatf("gap_symhold[%0d]", g), 32'(sym_o), 1);
      chk($sformatf("gap_symct[%0d]", g), 32'(sym_ct_o), 16);
    end
    for (int i = 16; i < 20; i++) begin
      send(1'b1, 2'b00);
      chk($sformatf("gap_post_err[%0d]", i), 32'(err_o), (i <= 17) ? 1 : 0);
    end
    chk("gap_bec", 32'(bit_err_ct_o), 3);

    // Reset mid-burst at index 16 abandons the burst
    do_reset();
    cfg(2'b10, 2'b01, 4'd3, 8'd0);
    for (int i = 0; i < 16; i++) send(1'b1, 2'b00);
    rst = 1'b0;
    send(1'b1, 2'b00);
    rst = 1'b1;
    chk("mrst_valid", 32'(valid_o), 0);
    chk("mrst_sym", 32'(sym_o), 0);
    chk("mrst_err", 32'(err_o), 0);
    chk("mrst_symct", 32'(sym_ct_o), 0);
    chk("mrst_bec", 32'(bit_err_ct_o), 0);
    chk("mrst_done", 32'(done_o), 0);
    for (int i = 0; i < 20; i++) begin
      send(1'b1, 2'b00);
      chk($sformatf("mrst_post_err[%0d]", i), 32'(err_o), (i >= 15 && i <= 17) ? 1 : 0);
    end
    chk("mrst_post_bec", 32'(bit_err_ct_o), 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net against a stalled run
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
